decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Decode stage of the 5-stage RV32I pipeline. Consumes instr_d, pc_d and pc_1d from the fetch stage's F/D register.
//  Contains a 32x32 register file, a control decoder and an immediate generator.
//  Detects load-use hazards and holds the decoded fields in the D/E pipeline register.
//  Feeds the execute stage and accepts the writeback port from the W stage.
// PARAMETERS
//  XLEN       32  datapath width
//  NREGS      32  register count; x0 hardwired to 0
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     asynchronous, active-low reset
//  instr_d      in   32    instruction from F/D register
//  pc_d         in   32    PC of instr_d (word address)
//  pc_1d        in   32    pc_d+1 (word address)
//  flush_e      in   1     branch/jump taken in EX (same signal drives the fetch PC mux)
//  regwrite_w   in   1     writeback enable
//  rd_w         in   5     writeback register index
//  result_w     in   32    writeback data
//  stall_fd     out  1     load-use hazard; fetch holds PC and the F/D register this cycle
//  regwrite_e   out  1     D/E register: register write enable
//  resultsrc_e  out  2     00 ALU, 01 memory, 10 pc_1
//  memwrite_e   out  1     store
//  branch_e     out  1     conditional branch
//  jump_e       out  1     jal/jalr
//  alusrc_e     out  1     0 = rd2, 1 = imm
//  aluctrl_e    out  3     000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
//  funct3_e     out  3     branch condition / load-store size
//  illegal_e    out  1     unsupported opcode or funct3
//  rd1_e, rd2_e out  32    register operands
//  imm_e        out  32    sign-extended immediate, byte offset as encoded
//  rs1_e, rs2_e, rd_e out 5  register indices, used by EX forwarding
//  pc_e, pc_1e  out  32    PC values carried forward
// BEHAVIOUR
//  Reset: every D/E output and stall_fd are 0. x1..x31 are cleared to 0.
//  Regfile write: on rising clk when regwrite_w=1 and rd_w!=0. Writes to x0 are ignored.
//  Regfile read: combinational. Bypass: if regwrite_w and rd_w!=0 and rd_w==rs, the read returns result_w.
//  Opcodes and decode:
//   - 0110011 R-type
//   - 0010011 I-ALU
//   - 0000011 load: resultsrc=01, add
//   - 0100011 store: memwrite, add, no regwrite
//   - 1100011 branch: sub, no regwrite
//   - 1101111 jal and 1100111 jalr: jump, resultsrc=10
//   - 0110111 lui: imm=U, rd1 forced to 0, add
//  ALU functions: funct3 000 add; R-type with funct7[5]=1 gives sub. 010 slt, 100 xor, 110 or, 111 and.
//  Unsupported funct3 (shifts 001/101, 011) or unknown opcode: illegal_e=1 and all control outputs 0.
//  Immediates: I, S, B (bit0=0), J (bit0=0) and U (low 12 bits =0) per the RV32I formats.
//  Hazard: stall_fd = resultsrc_e==01 & regwrite_e & rd_e!=0 & (rd_e==instr_d[19:15] | rd_e==instr_d[24:20]) & ~flush_e.
//   stall_fd is combinational.
//  D/E register update on each rising clk, with priority:
//   1. rst
//   2. flush_e: bubble (all control 0, indices/data 0)
//   3. stall_fd: bubble
//   4. otherwise load the decoded values
//  Latency: one cycle from instr_d to the *_e outputs.
//  Simultaneous writeback and read of the same register: the bypass returns the new value.
//  Reset asserted mid-operation: outputs clear immediately and asynchronously.
// TESTING
//  1. Reset low: all *_e = 0 and stall_fd = 0. Read of x5 after reset returns 0.
//  2. W writes x1=5 and x2=7, then instr 0x002081B3 (add x3,x1,x2).
//     -> next cycle: rd1_e=5, rd2_e=7, rd_e=3, aluctrl=000, regwrite_e=1.
//  3. Same-cycle bypass: regwrite_w=1, rd_w=1, result_w=0xA while decoding x1.
//     -> rd1_e=0xA. Write with rd_w=0 -> x0 still reads 0.
//  4. Load-use: 0x0000A283 (lw x5,0(x1)) followed by 0x00528333 (add x6,x5,x5).
//     -> stall_fd=1 for one cycle and a bubble enters E; the add reaches E one cycle later.
//  5. Branch 0xFE000EE3 (beq x0,x0,-4) -> imm_e=0xFFFFFFFC, branch_e=1, aluctrl=001, regwrite_e=0.
//  6. flush_e=1 together with a load-use stall -> stall_fd=0 and the E register is a bubble.
//     Opcode 0x7F -> illegal_e=1.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: register file, control decoder, immediate generator,
// load-use hazard detection and the D/E pipeline register.
module decode_stage #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     instr_d,
   input  logic [XLEN-1:0] pc_d,
   input  logic [XLEN-1:0] pc_1d,
   input  logic            flush_e,
   input  logic            regwrite_w,
   input  logic [4:0]      rd_w,
   input  logic [XLEN-1:0] result_w,
   output logic            stall_fd,
   output logic            regwrite_e,
   output logic [1:0]      resultsrc_e,
   output logic            memwrite_e,
   output logic            branch_e,
   output logic            jump_e,
   output logic            alusrc_e,
   output logic [2:0]      aluctrl_e,
   output logic [2:0]      funct3_e,
   output logic            illegal_e,
   output logic [XLEN-1:0] rd1_e,
   output logic [XLEN-1:0] rd2_e,
   output logic [XLEN-1:0] imm_e,
   output logic [4:0]      rs1_e,
   output logic [4:0]      rs2_e,
   output logic [4:0]      rd_e,
   output logic [XLEN-1:0] pc_e,
   output logic [XLEN-1:0] pc_1e
);

   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                          OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;
   localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                          ALU_OR = 3'b011, ALU_XOR = 3'b100, ALU_SLT = 3'b101;

   typedef struct packed {
      logic            regwrite;
      logic [1:0]      resultsrc;
      logic            memwrite;
      logic            branch;
      logic            jump;
      logic            alusrc;
      logic [2:0]      aluctrl;
      logic [2:0]      funct3;
      logic            illegal;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_1;
   } de_t;

   logic [XLEN-1:0] regs [NREGS];
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [4:0]      rs1, rs2, rd;
   logic [XLEN-1:0] rf_rd1, rf_rd2;
   logic            alu_ok;
   logic [2:0]      alu_fn;
   de_t             dec, de_q;

   assign opcode = instr_d[6:0];
   assign funct3 = instr_d[14:12];
   assign rs1    = instr_d[19:15];
   assign rs2    = instr_d[24:20];
   assign rd     = instr_d[11:7];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (regwrite_w && rd_w != 5'd0) begin
         regs[rd_w] <= result_w;
      end
   end

   // Writeback of the register being read this cycle is bypassed straight through.
   assign rf_rd1 = (rs1 == 5'd0) ? '0 :
                   (regwrite_w && rd_w == rs1) ? result_w : regs[rs1];
   assign rf_rd2 = (rs2 == 5'd0) ? '0 :
                   (regwrite_w && rd_w == rs2) ? result_w : regs[rs2];

   // ALU function for R-type and I-ALU; shifts and sltu are not supported.
   always_comb begin
      alu_ok = 1'b1;
      alu_fn = ALU_ADD;
      case (funct3)
         3'b000:  alu_fn = (opcode == OP_R && instr_d[30]) ? ALU_SUB : ALU_ADD;
         3'b010:  alu_fn = ALU_SLT;
         3'b100:  alu_fn = ALU_XOR;
         3'b110:  alu_fn = ALU_OR;
         3'b111:  alu_fn = ALU_AND;
         default: alu_ok = 1'b0;
      endcase
   end

   always_comb begin
      dec        = '0;
      dec.funct3 = funct3;
      dec.rd1    = rf_rd1;
      dec.rd2    = rf_rd2;
      dec.rs1    = rs1;
      dec.rs2    = rs2;
      dec.rd     = rd;
      dec.pc     = pc_d;
      dec.pc_1   = pc_1d;
      case (opcode)
         OP_R: begin
            dec.regwrite = 1'b1;
            dec.aluctrl  = alu_fn;
         end
         OP_I: begin
            dec.regwrite = 1'b1;
            dec.alusrc   = 1'b1;
            dec.aluctrl  = alu_fn;
            dec.imm      = {{20{instr_d[31]}}, instr_d[31:20]};
         end
         OP_LD: begin
            dec.regwrite  = 1'b1;
            dec.resultsrc = 2'b01;
            dec.alusrc    = 1'b1;
            dec.imm       = {{20{instr_d[31]}}, instr_d[31:20]};
         end
         OP_ST: begin
            dec.memwrite = 1'b1;
            dec.alusrc   = 1'b1;
            dec.imm      = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
         end
         OP_BR: begin
            dec.branch  = 1'b1;
            dec.aluctrl = ALU_SUB;
            dec.imm     = {{19{instr_d[31]}}, instr_d[31], instr_d[7], instr_d[30:25],
                           instr_d[11:8], 1'b0};
         end
         OP_JAL: begin
            dec.regwrite  = 1'b1;
            dec.jump      = 1'b1;
            dec.resultsrc = 2'b10;
            dec.imm       = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12], instr_d[20],
                             instr_d[30:21], 1'b0};
         end
         OP_JALR: begin
            dec.regwrite  = 1'b1;
            dec.jump      = 1'b1;
            dec.resultsrc = 2'b10;
            dec.alusrc    = 1'b1;
            dec.imm       = {{20{instr_d[31]}}, instr_d[31:20]};
         end
         OP_LUI: begin
            // lui computes 0 + imm; rs1 is zeroed too so EX forwarding cannot override it.
            dec.regwrite = 1'b1;
            dec.alusrc   = 1'b1;
            dec.rd1      = '0;
            dec.rs1      = 5'd0;
            dec.imm      = {instr_d[31:12], 12'b0};
         end
         default: dec.illegal = 1'b1;
      endcase
      if ((opcode == OP_R || opcode == OP_I) && !alu_ok) dec.illegal = 1'b1;
      if (dec.illegal) begin
         dec.regwrite  = 1'b0;
         dec.resultsrc = 2'b00;
         dec.memwrite  = 1'b0;
         dec.branch    = 1'b0;
         dec.jump      = 1'b0;
         dec.alusrc    = 1'b0;
         dec.aluctrl   = 3'b000;
      end
   end

   assign stall_fd = (de_q.resultsrc == 2'b01) && de_q.regwrite && (de_q.rd != 5'd0) &&
                     ((de_q.rd == rs1) || (de_q.rd == rs2)) && !flush_e;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                    de_q <= '0;
      else if (flush_e || stall_fd) de_q <= '0;
      else                         de_q <= dec;
   end

   assign regwrite_e  = de_q.regwrite;
   assign resultsrc_e = de_q.resultsrc;
   assign memwrite_e  = de_q.memwrite;
   assign branch_e    = de_q.branch;
   assign jump_e      = de_q.jump;
   assign alusrc_e    = de_q.alusrc;
   assign aluctrl_e   = de_q.aluctrl;
   assign funct3_e    = de_q.funct3;
   assign illegal_e   = de_q.illegal;
   assign rd1_e       = de_q.rd1;
   assign rd2_e       = de_q.rd2;
   assign imm_e       = de_q.imm;
   assign rs1_e       = de_q.rs1;
   assign rs2_e       = de_q.rs2;
   assign rd_e        = de_q.rd;
   assign pc_e        = de_q.pc;
   assign pc_1e       = de_q.pc_1;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] instr_d = 32'h0000_0013;
   logic [31:0] pc_d = '0, pc_1d = '0;
   logic        flush_e = 1'b0;
   logic        regwrite_w = 1'b0;
   logic [4:0]  rd_w = '0;
   logic [31:0] result_w = '0;
   logic        stall_fd, regwrite_e, memwrite_e, branch_e, jump_e, alusrc_e, illegal_e;
   logic [1:0]  resultsrc_e;
   logic [2:0]  aluctrl_e, funct3_e;
   logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc_1e;
   logic [4:0]  rs1_e, rs2_e, rd_e;

   int tests = 0;
   int fails = 0;

   decode_stage dut (
      .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d), .pc_1d(pc_1d),
      .flush_e(flush_e), .regwrite_w(regwrite_w), .rd_w(rd_w), .result_w(result_w),
      .stall_fd(stall_fd), .regwrite_e(regwrite_e), .resultsrc_e(resultsrc_e),
      .memwrite_e(memwrite_e), .branch_e(branch_e), .jump_e(jump_e), .alusrc_e(alusrc_e),
      .aluctrl_e(aluctrl_e), .funct3_e(funct3_e), .illegal_e(illegal_e),
      .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
      .rd_e(rd_e), .pc_e(pc_e), .pc_1e(pc_1e)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // All control outputs packed: regwrite,resultsrc,memwrite,branch,jump,alusrc,aluctrl,illegal
   function automatic logic [10:0] ctl();
      return {regwrite_e, resultsrc_e, memwrite_e, branch_e, jump_e, alusrc_e, aluctrl_e, illegal_e};
   endfunction

   task automatic test_reset();
      #12;
      tests++;
      if ({ctl(), stall_fd, rd1_e, rd2_e, imm_e, rs1_e, rs2_e, rd_e, pc_e, pc_1e, funct3_e} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: ctl=%h stall=%b rd1=%h imm=%h rd=%0d pc=%h", ctl(), stall_fd, rd1_e, imm_e, rd_e, pc_e);
      end
      @(negedge clk);
      rst = 1'b1;
      instr_d = 32'h0002_8033;                  // add x0,x5,x0
      tick();
      tests++;
      if (rd1_e !== 32'h0 || rs1_e !== 5'd5) begin
         fails++;
         $display("FAIL reset_x5_read: rd1=%h rs1=%0d expected 0 / 5", rd1_e, rs1_e);
      end
   endtask

   task automatic test_add();
      instr_d = 32'h0000_0013;
      regwrite_w = 1'b1; rd_w = 5'd1; result_w = 32'd5;
      tick();
      rd_w = 5'd2; result_w = 32'd7;
      tick();
      regwrite_w = 1'b0;
      instr_d = 32'h0020_81B3; pc_d = 32'h10; pc_1d = 32'h11;
      tick();
      tests++;
      if (rd1_e !== 32'd5 || rd2_e !== 32'd7 || rd_e !== 5'd3 || rs1_e !== 5'd1 || rs2_e !== 5'd2) begin
         fails++;
         $display("FAIL add_operands: rd1=%0d rd2=%0d rd=%0d rs1=%0d rs2=%0d expected 5 7 3 1 2", rd1_e, rd2_e, rd_e, rs1_e, rs2_e);
      end
      tests++;
      if (ctl() !== 11'b1_00_0_0_0_0_000_0 || pc_e !== 32'h10 || pc_1e !== 32'h11) begin
         fails++;
         $display("FAIL add_control: ctl=%b pc=%h pc1=%h expected 10000000000 10 11", ctl(), pc_e, pc_1e);
      end
   endtask

   task automatic test_bypass();
      instr_d = 32'h0020_81B3;
      regwrite_w = 1'b1; rd_w = 5'd1; result_w = 32'hA;
      tick();
      tests++;
      if (rd1_e !== 32'hA || rd2_e !== 32'd7) begin
         fails++;
         $display("FAIL bypass_same_cycle: rd1=%h rd2=%h expected a 7", rd1_e, rd2_e);
      end
      instr_d = 32'h0000_01B3;                  // add x3,x0,x0
      rd_w = 5'd0; result_w = 32'h55;
      tick();
      regwrite_w = 1'b0;
      tests++;
      if (rd1_e !== 32'h0 || rd2_e !== 32'h0) begin
         fails++;
         $display("FAIL x0_bypass: rd1=%h rd2=%h expected 0 0", rd1_e, rd2_e);
      end
      tick();
      tests++;
      if (rd1_e !== 32'h0) begin
         fails++;
         $display("FAIL x0_write: rd1=%h expected 0", rd1_e);
      end
   endtask

   task automatic test_load_use();
      instr_d = 32'h0000_A283;                  // lw x5,0(x1)
      tick();
      tests++;
      if (ctl() !== 11'b1_01_0_0_0_1_000_0 || rd_e !== 5'd5 || rd1_e !== 32'hA || funct3_e !== 3'b010) begin
         fails++;
         $display("FAIL load_decode: ctl=%b rd=%0d rd1=%h f3=%b", ctl(), rd_e, rd1_e, funct3_e);
      end
      instr_d = 32'h0052_8333;                  // add x6,x5,x5
      #1;
      tests++;
      if (stall_fd !== 1'b1) begin
         fails++;
         $display("FAIL load_use_stall: stall=%b expected 1", stall_fd);
      end
      tick();
      tests++;
      if (regwrite_e !== 1'b0 || rd_e !== 5'd0 || resultsrc_e !== 2'b00 || stall_fd !== 1'b0) begin
         fails++;
         $display("FAIL load_use_bubble: regwrite=%b rd=%0d rs=%b stall=%b expected 0 0 0 0", regwrite_e, rd_e, resultsrc_e, stall_fd);
      end
      tick();
      tests++;
      if (regwrite_e !== 1'b1 || rd_e !== 5'd6 || rs1_e !== 5'd5 || rs2_e !== 5'd5 || resultsrc_e !== 2'b00) begin
         fails++;
         $display("FAIL load_use_release: regwrite=%b rd=%0d rs1=%0d rs2=%0d", regwrite_e, rd_e, rs1_e, rs2_e);
      end
   endtask

   task automatic test_branch();
      instr_d = 32'hFE00_0EE3;                  // beq x0,x0,-4
      tick();
      tests++;
      if (imm_e !== 32'hFFFF_FFFC || branch_e !== 1'b1 || aluctrl_e !== 3'b001 || regwrite_e !== 1'b0 || alusrc_e !== 1'b0) begin
         fails++;
         $display("FAIL branch_decode: imm=%h br=%b alu=%b rw=%b expected fffffffc 1 001 0", imm_e, branch_e, aluctrl_e, regwrite_e);
      end
   endtask

   task automatic test_flush();
      instr_d = 32'h0000_A283;
      pc_d = 32'h20; pc_1d = 32'h21;
      tick();
      instr_d = 32'h0052_8333;
      flush_e = 1'b1;
      #1;
      tests++;
      if (stall_fd !== 1'b0) begin
         fails++;
         $display("FAIL flush_stall: stall=%b expected 0", stall_fd);
      end
      tick();
      flush_e = 1'b0;
      tests++;
      if (ctl() !== '0 || rd_e !== 5'd0 || pc_e !== 32'h0 || rd1_e !== 32'h0) begin
         fails++;
         $display("FAIL flush_bubble: ctl=%b rd=%0d pc=%h rd1=%h expected all 0", ctl(), rd_e, pc_e, rd1_e);
      end
   endtask

   task automatic test_misc_decode();
      instr_d = 32'h0000_007F;
      tick();
      tests++;
      if (illegal_e !== 1'b1 || ctl() !== 11'b0_00_0_0_0_0_000_1) begin
         fails++;
         $display("FAIL illegal_opcode: ctl=%b expected 00000000001", ctl());
      end
      instr_d = 32'h0010_9093;                  // slli x1,x1,1
      tick();
      tests++;
      if (illegal_e !== 1'b1 || regwrite_e !== 1'b0) begin
         fails++;
         $display("FAIL illegal_shift: illegal=%b rw=%b expected 1 0", illegal_e, regwrite_e);
      end
      instr_d = 32'h4020_81B3;                  // sub x3,x1,x2
      tick();
      tests++;
      if (aluctrl_e !== 3'b001 || illegal_e !== 1'b0) begin
         fails++;
         $display("FAIL sub_decode: alu=%b illegal=%b expected 001 0", aluctrl_e, illegal_e);
      end
      instr_d = 32'h0000_A3B7;                  // lui x7,0xA (rs1 field = x1)
      tick();
      tests++;
      if (imm_e !== 32'h0000_A000 || rd1_e !== 32'h0 || alusrc_e !== 1'b1 || regwrite_e !== 1'b1 || rd_e !== 5'd7) begin
         fails++;
         $display("FAIL lui_decode: imm=%h rd1=%h alusrc=%b rw=%b rd=%0d", imm_e, rd1_e, alusrc_e, regwrite_e, rd_e);
      end
      instr_d = 32'h0020_A223;                  // sw x2,4(x1)
      tick();
      tests++;
      if (imm_e !== 32'h4 || memwrite_e !== 1'b1 || regwrite_e !== 1'b0 || alusrc_e !== 1'b1 || rd2_e !== 32'd7) begin
         fails++;
         $display("FAIL store_decode: imm=%h mw=%b rw=%b rd2=%h", imm_e, memwrite_e, regwrite_e, rd2_e);
      end
      instr_d = 32'h0080_00EF;                  // jal x1,8
      tick();
      tests++;
      if (imm_e !== 32'h8 || jump_e !== 1'b1 || resultsrc_e !== 2'b10 || regwrite_e !== 1'b1) begin
         fails++;
         $display("FAIL jal_decode: imm=%h jump=%b rs=%b rw=%b expected 8 1 10 1", imm_e, jump_e, resultsrc_e, regwrite_e);
      end
   endtask

   task automatic test_async_reset();
      #2;
      rst = 1'b0;
      #1;
      tests++;
      if (jump_e !== 1'b0 || regwrite_e !== 1'b0 || imm_e !== 32'h0) begin
         fails++;
         $display("FAIL async_reset: jump=%b rw=%b imm=%h expected 0 0 0", jump_e, regwrite_e, imm_e);
      end
      @(negedge clk);
      rst = 1'b1;
      instr_d = 32'h0020_81B3;
      tick();
      tests++;
      if (rd1_e !== 32'h0 || rd2_e !== 32'h0) begin
         fails++;
         $display("FAIL reset_clears_regs: rd1=%h rd2=%h expected 0 0", rd1_e, rd2_e);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_bypass();
      test_load_use();
      test_branch();
      test_flush();
      test_misc_decode();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
